// File: rtl/tdc_enc_pkg.sv
// Shared definitions for the ring fine encoder: bubble-correction levels,
// level clamping and the width helper used for tap-index ports.
package tdc_enc_pkg;

    typedef enum logic [1:0] {
        LVL_NONE   = 2'd1,
        LVL_SINGLE = 2'd2,
        LVL_DOUBLE = 2'd3
    } lvl_e;

    // Out-of-range requests saturate to the nearest supported level.
    function automatic lvl_e clamp_level(input logic [2:0] lvl);
        lvl_e r;
        case (lvl)
            3'd0, 3'd1: r = LVL_NONE;
            3'd2:       r = LVL_SINGLE;
            default:    r = LVL_DOUBLE;
        endcase
        return r;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/tdc_ring_fine_encoder_if.sv
// Sample-in / result-out bundle of the ring fine encoder.
interface tdc_ring_fine_encoder_if
    import tdc_enc_pkg::*;
#(
    parameter int TAP_W = 32
);
    localparam int BIN_W = clog2(TAP_W);

    logic             valid_in;
    logic [TAP_W-1:0] code_in;
    logic [2:0]       level;
    logic             valid_out;
    logic [BIN_W-1:0] bin_out;
    logic             error_out;
    logic             bubble_out;

    modport master (
        output valid_in, code_in, level,
        input  valid_out, bin_out, error_out, bubble_out
    );

    modport slave (
        input  valid_in, code_in, level,
        output valid_out, bin_out, error_out, bubble_out
    );

endinterface

// File: rtl/tdc_ring_edge_encode.sv
// Two-level one-hot to binary encoder for the ring edge vector; flags
// vectors that carry no edge or more than one edge.
module tdc_ring_edge_encode
    import tdc_enc_pkg::*;
#(
    parameter int TAP_W = 32,
    parameter int GRP_W = 8,
    localparam int BIN_W = clog2(TAP_W)
) (
    input  logic [TAP_W-1:0] edge_vec,
    output logic [BIN_W-1:0] index,
    output logic             error
);
    localparam int NGRP = TAP_W / GRP_W;

    logic [NGRP-1:0]  grp_hit;
    logic [NGRP-1:0]  grp_multi;
    logic             multi_grp;
    logic [BIN_W-1:0] grp_base;
    logic [GRP_W-1:0] sel;
    logic [BIN_W-1:0] lsb;

    // x & (x-1) is non-zero exactly when x has two or more bits set.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        logic [GRP_W-1:0] slice;
        assign slice         = edge_vec[gi*GRP_W +: GRP_W];
        assign grp_hit[gi]   = |slice;
        assign grp_multi[gi] = |(slice & (slice - GRP_W'(1)));
    end

    assign multi_grp = |(grp_hit & (grp_hit - NGRP'(1)));

    always_comb begin
        grp_base = '0;
        sel      = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (grp_hit[g]) begin
                grp_base = BIN_W'(g * GRP_W);
                sel      = edge_vec[g*GRP_W +: GRP_W];
            end
        end
    end

    always_comb begin
        lsb = '0;
        for (int b = GRP_W - 1; b >= 0; b--) begin
            if (sel[b]) lsb = BIN_W'(b);
        end
    end

    assign error = ~(|grp_hit) | multi_grp | (|grp_multi);
    assign index = error ? '0 : (grp_base | lsb);

endmodule

// File: rtl/tdc_ring_fine_encoder.sv
// Three-stage fine-phase encoder: capture, bubble fill + edge detect,
// encode. Also keeps a saturating count of invalid codes.
module tdc_ring_fine_encoder
    import tdc_enc_pkg::*;
#(
    parameter int TAP_W = 32,
    parameter int GRP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      err_count,
    tdc_ring_fine_encoder_if.slave bus
);
    localparam int BIN_W = clog2(TAP_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s1_valid_reg;
    logic [TAP_W-1:0] s1_code_reg;
    logic [1:0]       s1_level_reg;

    logic             s2_valid_reg;
    logic [TAP_W-1:0] s2_edge_reg;
    logic             s2_bubble_reg;

    logic             s3_valid_reg;
    logic [BIN_W-1:0] s3_bin_reg;
    logic             s3_error_reg;
    logic             s3_bubble_reg;
    logic [CNT_W-1:0] err_count_reg;

    logic [TAP_W-1:0] single_fill;
    logic [TAP_W-1:0] double_pair;
    logic [TAP_W-1:0] double_fill;
    logic [TAP_W-1:0] filled;
    logic [TAP_W-1:0] edge_next;
    logic             bubble_next;
    logic [BIN_W-1:0] enc_index;
    logic             enc_error;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_reg <= 1'b0;
            s1_code_reg  <= '0;
            s1_level_reg <= '0;
        end else begin
            s1_valid_reg <= bus.valid_in;
            s1_code_reg  <= bus.code_in;
            s1_level_reg <= clamp_level(bus.level);
        end
    end

    // Fill terms look only at the captured raw code, never at each other,
    // so one pass is enough and the logic depth is fixed.
    for (genvar gi = 0; gi < TAP_W; gi++) begin : g_fill
        localparam int PREV  = (gi + TAP_W - 1) % TAP_W;
        localparam int NEXT  = (gi + 1) % TAP_W;
        localparam int NEXT2 = (gi + 2) % TAP_W;

        assign single_fill[gi] = ~s1_code_reg[gi] & s1_code_reg[PREV] & s1_code_reg[NEXT];
        assign double_pair[gi] = ~s1_code_reg[gi] & ~s1_code_reg[NEXT]
                               & s1_code_reg[PREV] & s1_code_reg[NEXT2];
        assign double_fill[gi] = double_pair[gi] | double_pair[PREV];
        assign edge_next[gi]   = filled[gi] & ~filled[PREV];
    end

    assign filled = s1_code_reg
                  | ((s1_level_reg >= LVL_SINGLE) ? single_fill : '0)
                  | ((s1_level_reg == LVL_DOUBLE) ? double_fill : '0);
    assign bubble_next = |(filled ^ s1_code_reg);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_reg  <= 1'b0;
            s2_edge_reg   <= '0;
            s2_bubble_reg <= 1'b0;
        end else begin
            s2_valid_reg  <= s1_valid_reg;
            s2_edge_reg   <= edge_next;
            s2_bubble_reg <= bubble_next;
        end
    end

    tdc_ring_edge_encode #(
        .TAP_W (TAP_W),
        .GRP_W (GRP_W)
    ) u_edge_encode (
        .edge_vec (s2_edge_reg),
        .index    (enc_index),
        .error    (enc_error)
    );

    // Result fields hold their last value across pipeline bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s3_valid_reg  <= 1'b0;
            s3_bin_reg    <= '0;
            s3_error_reg  <= 1'b0;
            s3_bubble_reg <= 1'b0;
        end else begin
            s3_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                s3_bin_reg    <= enc_index;
                s3_error_reg  <= enc_error;
                s3_bubble_reg <= s2_bubble_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count_reg <= '0;
        end else if (cnt_clr) begin
            err_count_reg <= '0;
        end else if (s3_valid_reg && s3_error_reg && (err_count_reg != CNT_MAX)) begin
            err_count_reg <= err_count_reg + CNT_W'(1);
        end
    end

    assign bus.valid_out  = s3_valid_reg;
    assign bus.bin_out    = s3_bin_reg;
    assign bus.error_out  = s3_error_reg;
    assign bus.bubble_out = s3_bubble_reg;
    assign err_count      = err_count_reg;

endmodule

// File: tb/tb_tdc_ring_fine_encoder.sv
// Directed bench for the ring fine encoder: single transactions with
// hand-computed results, counter saturation/clear, streaming and reset.
module tb_tdc_ring_fine_encoder;

    logic        clk;
    logic        rstn;
    logic        cnt_clr;
    logic [15:0] err_count;
    logic        cnt_clr64;
    logic [15:0] err_count64;

    int total;
    int bad;
    logic [15:0] exp_cnt;

    tdc_ring_fine_encoder_if #(.TAP_W(32)) bus32 ();
    tdc_ring_fine_encoder_if #(.TAP_W(64)) bus64 ();

    tdc_ring_fine_encoder #(.TAP_W(32), .GRP_W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cnt_clr   (cnt_clr),
        .err_count (err_count),
        .bus       (bus32.slave)
    );

    tdc_ring_fine_encoder #(.TAP_W(64), .GRP_W(8), .CNT_W(16)) dut64 (
        .clk       (clk),
        .rstn      (rstn),
        .cnt_clr   (cnt_clr64),
        .err_count (err_count64),
        .bus       (bus64.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] code, input logic [2:0] lvl,
                           input int exp_bin, input logic exp_err, input logic exp_bub,
                           input logic clr_at_out);
        @(negedge clk);
        bus32.valid_in = 1'b1;
        bus32.code_in  = code;
        bus32.level    = lvl;
        @(negedge clk);
        bus32.valid_in = 1'b0;
        @(negedge clk);
        chk({tag, ".early"}, bus32.valid_out, 0);
        @(negedge clk);
        chk({tag, ".vo"},  bus32.valid_out, 1);
        chk({tag, ".bin"}, bus32.bin_out, exp_bin);
        chk({tag, ".err"}, bus32.error_out, exp_err);
        chk({tag, ".bub"}, bus32.bubble_out, exp_bub);
        $display("txn %s code=%08h lvl=%0d bin=%0d err=%0b bub=%0b", tag, code, lvl,
                 bus32.bin_out, bus32.error_out, bus32.bubble_out);
        if (clr_at_out) begin
            cnt_clr = 1'b1;
            exp_cnt = '0;
        end else if (exp_err && exp_cnt != 16'hFFFF) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        @(negedge clk);
        cnt_clr = 1'b0;
        chk({tag, ".vo_off"},   bus32.valid_out, 0);
        chk({tag, ".bin_hold"}, bus32.bin_out, exp_bin);
        chk({tag, ".cnt"},      err_count, exp_cnt);
    endtask

    initial begin
        logic [31:0] base;
        total           = 0;
        bad             = 0;
        exp_cnt         = '0;
        base            = 32'h0000000F;
        rstn            = 1'b0;
        cnt_clr         = 1'b0;
        cnt_clr64       = 1'b0;
        bus32.valid_in  = 1'b0;
        bus32.code_in   = '0;
        bus32.level     = 3'd1;
        bus64.valid_in  = 1'b0;
        bus64.code_in   = '0;
        bus64.level     = 3'd1;

        repeat (2) @(negedge clk);
        chk("rst.vo",  bus32.valid_out, 0);
        chk("rst.bin", bus32.bin_out, 0);
        chk("rst.err", bus32.error_out, 0);
        chk("rst.bub", bus32.bubble_out, 0);
        chk("rst.cnt", err_count, 0);
        rstn = 1'b1;

        // invalid codes, counter steps 1,2,3
        run_one("zeros",  32'h00000000, 3'd1, 0, 1'b1, 1'b0, 1'b0);
        run_one("ones",   32'hFFFFFFFF, 3'd1, 0, 1'b1, 1'b0, 1'b0);
        run_one("tworun", 32'h00F000F0, 3'd1, 0, 1'b1, 1'b0, 1'b0);

        // valid codes
        run_one("basic",  32'h000000F0, 3'd1, 4,  1'b0, 1'b0, 1'b0);
        run_one("wrap",   32'hE0000003, 3'd1, 29, 1'b0, 1'b0, 1'b0);
        run_one("bub_l2", 32'h00000B00, 3'd2, 8,  1'b0, 1'b1, 1'b0);
        run_one("bub_l3", 32'h00001300, 3'd3, 8,  1'b0, 1'b1, 1'b0);
        run_one("bub_l7", 32'h00001300, 3'd7, 8,  1'b0, 1'b1, 1'b0);

        // bubbles left uncorrected, multi-hot inside one group
        run_one("bub_l1",  32'h00000B00, 3'd1, 0, 1'b1, 1'b0, 1'b0);
        run_one("bub_l0",  32'h00000B00, 3'd0, 0, 1'b1, 1'b0, 1'b0);
        run_one("dbl_l2",  32'h00001300, 3'd2, 0, 1'b1, 1'b0, 1'b0);
        run_one("grpmult", 32'h00000011, 3'd1, 0, 1'b1, 1'b0, 1'b0);

        // saturation: 2^16+5 back-to-back errors
        @(negedge clk);
        bus32.valid_in = 1'b1;
        bus32.code_in  = '0;
        bus32.level    = 3'd1;
        repeat (65541) @(negedge clk);
        bus32.valid_in = 1'b0;
        repeat (4) @(negedge clk);
        exp_cnt = 16'hFFFF;
        chk("sat.cnt", err_count, exp_cnt);
        $display("txn saturate cnt=%0h", err_count);

        // clear wins over a simultaneous increment
        run_one("clr_sat",  32'h00000000, 3'd1, 0, 1'b1, 1'b0, 1'b1);
        run_one("err_a",    32'h00000000, 3'd1, 0, 1'b1, 1'b0, 1'b0);
        run_one("clr_err",  32'h00000000, 3'd1, 0, 1'b1, 1'b0, 1'b1);
        run_one("err_b",    32'h00000000, 3'd1, 0, 1'b1, 1'b0, 1'b0);

        // 10 back-to-back samples
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (t >= 3 && t < 13) begin
                chk("strm.vo",  bus32.valid_out, 1);
                chk("strm.bin", bus32.bin_out, t - 3);
                $display("txn stream idx=%0d bin=%0d", t - 3, bus32.bin_out);
            end else if (t == 13) begin
                chk("strm.vo_end", bus32.valid_out, 0);
            end
            if (t < 10) begin
                bus32.valid_in = 1'b1;
                bus32.code_in  = base << t;
            end else begin
                bus32.valid_in = 1'b0;
            end
        end

        // reset mid-stream after two results
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (t >= 3) begin
                chk("mid.vo",  bus32.valid_out, 1);
                chk("mid.bin", bus32.bin_out, t - 1);
            end
            bus32.valid_in = 1'b1;
            bus32.code_in  = base << (t + 2);
        end
        @(negedge clk);
        rstn           = 1'b0;
        bus32.valid_in = 1'b0;
        #1;
        chk("mid.rst_vo",  bus32.valid_out, 0);
        chk("mid.rst_bin", bus32.bin_out, 0);
        chk("mid.rst_err", bus32.error_out, 0);
        chk("mid.rst_bub", bus32.bubble_out, 0);
        chk("mid.rst_cnt", err_count, 0);
        $display("txn midstream reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("mid.post_vo", bus32.valid_out, 0);
        end

        // 64-tap wrap
        @(negedge clk);
        bus64.valid_in = 1'b1;
        bus64.code_in  = 64'h8000000000000001;
        bus64.level    = 3'd1;
        @(negedge clk);
        bus64.valid_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("w64.vo",  bus64.valid_out, 1);
        chk("w64.bin", bus64.bin_out, 63);
        chk("w64.err", bus64.error_out, 0);
        chk("w64.bub", bus64.bubble_out, 0);
        chk("w64.cnt", err_count64, 0);
        $display("txn wrap64 bin=%0d err=%0b", bus64.bin_out, bus64.error_out);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
